// File: rtl/relu_maxpool_pkg.sv
// Shared definitions for the ReLU + 2x2 max-pool stage: layer modes, map geometry
// and FSM state encodings, common with the upstream quantizer.
package relu_maxpool_pkg;

  localparam int DATA_BW     = 8;
  localparam int CONV1_WIDTH = 24;
  localparam int CONV2_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_CONV1 = 2'd1,
    MODE_CONV2 = 2'd2,
    MODE_DONE  = 2'd3
  } layer_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_e;

endpackage

// File: rtl/pool_row_buf.sv
// Row buffer of horizontal partial maxima: one synchronous write port and one
// combinational read port, both indexed by the pooled column.
module pool_row_buf #(
  parameter int DEPTH   = 12,
  parameter int WIDTH   = 8,
  parameter int ADDR_BW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_BW-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [ADDR_BW-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; every odd-row read of an entry is
  // preceded by an even-row write of it in the same map.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/relu_maxpool.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling over one raster-order feature
// map per start; one pooled value per window, pooled on the fly via a row buffer.
module relu_maxpool #(
  parameter int DATA_BW   = 8,
  parameter int MAX_WIDTH = 24
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_BW-1:0] in_data,
  output logic               out_valid,
  output logic [DATA_BW-1:0] out_data,
  output logic               busy,
  output logic               done
);
  import relu_maxpool_pkg::*;

  localparam int CNT_BW  = $clog2(MAX_WIDTH);
  localparam int ADDR_BW = $clog2(MAX_WIDTH / 2);
  localparam int MAG_BW  = DATA_BW - 1;

  pool_state_e        state;
  logic [CNT_BW-1:0]  w_last;
  logic [CNT_BW-1:0]  col;
  logic [CNT_BW-1:0]  row;
  logic [MAG_BW-1:0]  h_reg;

  logic               accept;
  logic               col_wrap;
  logic               last_sample;
  logic [MAG_BW-1:0]  relu_val;
  logic [MAG_BW-1:0]  hmax;
  logic [DATA_BW-1:0] hmax_ext;
  logic [DATA_BW-1:0] rb_rdata;
  logic [DATA_BW-1:0] pooled;
  logic [ADDR_BW-1:0] rb_addr;
  logic               rb_we;

  assign accept      = (state == ST_RUN) && in_valid;
  assign col_wrap    = (col == w_last);
  assign last_sample = col_wrap && (row == w_last);

  // After ReLU the sign bit is always zero, so comparisons run on the magnitude bits.
  assign relu_val = in_data[DATA_BW-1] ? '0 : in_data[MAG_BW-1:0];
  assign hmax     = (h_reg > relu_val) ? h_reg : relu_val;
  assign hmax_ext = {1'b0, hmax};
  assign pooled   = (hmax_ext > rb_rdata) ? hmax_ext : rb_rdata;

  assign rb_addr = ADDR_BW'(col >> 1);
  assign rb_we   = accept && col[0] && !row[0];

  pool_row_buf #(
    .DEPTH   (MAX_WIDTH / 2),
    .WIDTH   (DATA_BW),
    .ADDR_BW (ADDR_BW)
  ) u_row_buf (
    .clk   (clk),
    .we    (rb_we),
    .waddr (rb_addr),
    .wdata (hmax_ext),
    .raddr (rb_addr),
    .rdata (rb_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= ST_IDLE;
      w_last    <= '0;
      col       <= '0;
      row       <= '0;
      h_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            col    <= '0;
            row    <= '0;
            w_last <= (mode == MODE_CONV2) ? CNT_BW'(CONV2_WIDTH - 1)
                                           : CNT_BW'(CONV1_WIDTH - 1);
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!col[0]) begin
              h_reg <= relu_val;
            end else if (row[0]) begin
              out_data  <= pooled;
              out_valid <= 1'b1;
            end
            if (col_wrap) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_sample) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool.sv
// Self-checking bench for relu_maxpool: randomized and directed maps compared
// against a window-by-window max-of-ReLU reference model.
module tb_relu_maxpool;

  logic       clk = 1'b0;
  logic       srst;
  logic [1:0] mode;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  int stim_q[$];
  int out_q[$];
  int done_cnt;
  int done_with_last;
  int busy_at_done;
  int outs_at_done;

  relu_maxpool #(.DATA_BW(8), .MAX_WIDTH(24)) dut (
    .clk       (clk),
    .srst      (srst),
    .mode      (mode),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) out_q.push_back(int'(out_data));
    if (done) begin
      done_cnt++;
      done_with_last = int'(out_valid);
      busy_at_done   = int'(busy);
      outs_at_done   = out_q.size();
    end
  end

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int relu(input int s);
    return (s < 0) ? 0 : s;
  endfunction

  // Each pooled output is the largest rectified sample of its 2x2 window.
  function automatic void build_expected(input int w, output int q[$]);
    q = {};
    for (int i = 0; i < w / 2; i++)
      for (int j = 0; j < w / 2; j++) begin
        int m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            int v = relu(stim_q[(2 * i + dr) * w + 2 * j + dc]);
            if (v > m) m = v;
          end
        q.push_back(m);
      end
  endfunction

  task automatic run_map(input string name, input logic [1:0] m, input int w,
                         input int gap_pct, input int ignore_at);
    int exp_q[$];
    int cyc;
    build_expected(w, exp_q);
    out_q.delete();
    done_cnt = 0;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, "_busy_rise"}, int'(busy), 1);
    for (int idx = 0; idx < stim_q.size(); idx++) begin
      if ($urandom_range(99) < gap_pct) begin
        int gaps = $urandom_range(1, 2);
        for (int g = 0; g < gaps; g++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = 8'(stim_q[idx]);
      if (idx == ignore_at) begin
        start = 1'b1;
        mode  = 2'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      mode  = m;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_out_count"}, out_q.size(), exp_q.size());
    check({name, "_done_with_last"}, done_with_last, 1);
    check({name, "_outs_at_done"}, outs_at_done, exp_q.size());
    check({name, "_busy_at_done"}, busy_at_done, 0);
    check({name, "_busy_idle"}, int'(busy), 0);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check($sformatf("%s_out%0d", name, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    srst     = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    mode     = 2'd2;
    in_data  = 8'($urandom);
    done_cnt = 0;

    // Reset held with start and in_valid asserted
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      in_data = 8'($urandom);
      check($sformatf("rst%0d_out_valid", c), int'(out_valid), 0);
      check($sformatf("rst%0d_out_data", c), int'(out_data), 0);
      check($sformatf("rst%0d_busy", c), int'(busy), 0);
      check($sformatf("rst%0d_done", c), int'(done), 0);
    end
    srst     = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", int'(busy), 0);

    // CONV2 ramp
    stim_q = {};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) stim_q.push_back(r * 8 + c);
    run_map("ramp", 2'd2, 8, 0, -1);
    if (out_q.size() == 16) begin
      check("ramp_first", out_q[0], 9);
      check("ramp_last", out_q[15], 63);
    end else begin
      check("ramp_size_for_ends", out_q.size(), 16);
    end

    // ReLU clamping
    stim_q = {};
    for (int i = 0; i < 64; i++) stim_q.push_back(-5);
    stim_q[1 * 8 + 1] = -128;
    stim_q[6 * 8 + 7] = 3;
    run_map("relu", 2'd2, 8, 0, -1);

    // CONV1 random with gaps
    stim_q = {};
    for (int i = 0; i < 576; i++) stim_q.push_back(int'($urandom_range(0, 255)) - 128);
    run_map("conv1_rand", 2'd1, 24, 30, -1);

    // Mid-map reset, then a clean CONV2 map
    mode  = 2'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    srst     = 1'b0;
    in_valid = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    out_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stale_outputs", out_q.size(), 0);
    stim_q = {};
    for (int i = 0; i < 64; i++) stim_q.push_back(int'($urandom_range(0, 255)) - 128);
    run_map("after_rst", 2'd2, 8, 0, -1);

    // start with CONV2 mode pulsed during a CONV1 run must be ignored
    stim_q = {};
    for (int i = 0; i < 576; i++) stim_q.push_back(int'($urandom_range(0, 255)) - 128);
    run_map("ign_start", 2'd1, 24, 10, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
